// File: rtl/icache.sv
// icache - direct-mapped instruction cache between fetch and instruction memory.
//
// A lookup is answered combinationally: on a hit ir_code carries the cached
// word, otherwise ir_code is a NOP and hit is low. A miss refills the whole
// line word by word over a req/ack handshake, lowest offset first, while
// fetch stalls.
//
// Parameters:
//   LINES       number of lines (power of two, >= 2)
//   LINE_WORDS  32-bit words per line (power of two, >= 2)
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   pc, req, flush        fetch address, lookup request, invalidate-all
//   ir_code, hit          instruction word (NOP on miss), hit flag
//   mem_req, mem_addr     word read request and word-aligned address
//   mem_ack, mem_rdata    read acknowledge and data
//   perf_hits/misses      hit and miss counters (only with ICACHE_PERF_EN)
//
// Optional feature macro: ICACHE_PERF_EN adds the performance counters.
module icache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        req,
  input  logic        flush,
  output logic [31:0] ir_code,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);

  localparam int WO = $clog2(LINE_WORDS);
  localparam int IX = $clog2(LINES);
  localparam int TW = 32 - IX - WO - 2;
  localparam logic [31:0]   NOP       = 32'h0000_0013;
  localparam logic [WO-1:0] LAST_WORD = WO'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [31:0]      data [LINES*LINE_WORDS];

  logic [TW-1:0] miss_tag;
  logic [IX-1:0] miss_idx;
  logic [WO-1:0] cnt;
  logic          abort;

  logic [WO-1:0] pc_off;
  logic [IX-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  logic          lookup_hit;
  logic          start_miss;
  logic          fill_word;
  logic          fill_last;

  assign pc_off = pc[WO+1:2];
  assign pc_idx = pc[IX+WO+1:WO+2];
  assign pc_tag = pc[31:IX+WO+2];

  assign lookup_hit = req && valid[pc_idx] && (tags[pc_idx] == pc_tag);

  // Lookup/refill control. mem_req and mem_addr depend only on registered
  // state, so the address is stable for the whole handshake and both drop
  // as soon as reset forces the state back to IDLE.
  always_comb begin
    state_next = state;
    hit        = 1'b0;
    ir_code    = NOP;
    mem_req    = 1'b0;
    mem_addr   = '0;
    start_miss = 1'b0;
    fill_word  = 1'b0;
    fill_last  = 1'b0;
    case (state)
      IDLE: begin
        hit = lookup_hit;
        if (lookup_hit) begin
          ir_code = data[{pc_idx, pc_off}];
        end
        // flush wins over miss detection so no refill starts into a
        // cache that is being invalidated
        if (req && !lookup_hit && !flush) begin
          start_miss = 1'b1;
          state_next = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag, miss_idx, cnt, 2'b00};
        if (mem_ack) begin
          fill_word = 1'b1;
          if (cnt == LAST_WORD) begin
            fill_last  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Miss bookkeeping and valid bits. A flush during refill only marks the
  // line as aborted; the handshake still completes so memory never sees a
  // dropped request. A flush in the completing cycle also keeps the line
  // invalid because the clear-all takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      cnt      <= '0;
      abort    <= 1'b0;
    end else begin
      if (start_miss) begin
        miss_tag <= pc_tag;
        miss_idx <= pc_idx;
        cnt      <= '0;
        abort    <= 1'b0;
      end
      if (fill_word) begin
        cnt <= cnt + 1'b1;
      end
      if (state == REFILL && flush) begin
        abort <= 1'b1;
      end
      if (fill_last) begin
        abort <= 1'b0;
      end
      if (flush) begin
        valid <= '0;
      end else if (fill_last && !abort) begin
        valid[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (fill_word) begin
      data[{miss_idx, cnt}] <= mem_rdata;
    end
    if (fill_last) begin
      tags[miss_idx] <= miss_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (state == IDLE && hit) begin
        perf_hits <= perf_hits + 32'd1;
      end
      if (start_miss) begin
        perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache that answers the fetch stage's per-cycle instruction lookups. It sits between `fetch` and the instruction memory port. It returns the instruction word combinationally on a hit, and returns a NOP with `hit` low on a miss. On a miss it refills one whole line from backing memory with a word-serial request/acknowledge handshake; `fetch` stalls until `hit` returns.

## Interface

Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `pc`, input, 32: fetch address; bits [1:0] are ignored.
- `req`, input, 1: fetch requests an instruction this cycle.
- `flush`, input, 1: invalidate every line (fence.i).
- `ir_code`, output, 32: instruction word on a hit, otherwise `32'h00000013` (NOP).
- `hit`, output, 1: `ir_code` is valid for `pc`.
- `mem_req`, output, 1: word read request to backing memory.
- `mem_addr`, output, 32: word-aligned read address.
- `mem_ack`, input, 1: memory returns `mem_rdata` this cycle.
- `mem_rdata`, input, 32: read data, valid when `mem_ack` is high.
- `perf_hits`, output, 32: present only with `ICACHE_PERF_EN`.
- `perf_misses`, output, 32: present only with `ICACHE_PERF_EN`.

## Operation

- **Address split.** WO = log2(`LINE_WORDS`), IX = log2(`LINES`).
  - Word offset: `pc[WO+1:2]`.
  - Index: `pc[IX+WO+1:WO+2]`.
  - Tag: `pc[31:IX+WO+2]`.
- **Storage.**
  - One valid bit and one tag per line.
  - Data array of `LINES*LINE_WORDS` words.
  - Arrays use asynchronous read and synchronous write.
- **FSM state IDLE.**
  - `hit = req && valid[idx] && tag[idx]==pc_tag`.
  - `ir_code` = the selected data word when `hit` is 1, otherwise NOP.
  - If `req && !hit && !flush`: latch `{pc_tag, idx}` as the miss line, clear the word counter, and go to REFILL.
- **FSM state REFILL.**
  - `hit` = 0 and `ir_code` = NOP regardless of `pc`.
  - `mem_req` = 1 and `mem_addr = {miss_tag, miss_idx, cnt, 2'b00}`.
  - Words are fetched in order from offset 0 up to `LINE_WORDS-1`.
  - On each `mem_ack`, write `mem_rdata` to data[miss_idx][cnt] and increment `cnt`.
  - On the ack with `cnt == LINE_WORDS-1`:
    - Write `tag[miss_idx]` = miss tag.
    - Set `valid[miss_idx]`, unless the abort flag is set.
    - Clear the abort flag and go to IDLE.
- **Flush.**
  - Clears all valid bits at the clock edge.
  - In IDLE, flush has priority over miss detection: no refill starts, and `hit` is still evaluated combinationally in the flush cycle.
  - In REFILL, flush sets the abort flag. The refill runs to completion so the memory protocol stays intact, but the line is not validated.
- **Memory handshake.**
  - `mem_addr` is stable while `mem_req` is high and `mem_ack` is low.
  - `mem_req` may stay high across consecutive words, with the address advancing the cycle after each ack.
  - `mem_ack` while `mem_req` is low is ignored.
- **Changing `pc` during REFILL** has no effect on the refill in progress. The lookup resumes in IDLE with the current `pc`.

## Timing

- **Reset values.**
  - State IDLE, all valid bits 0, `cnt` 0, abort flag 0.
  - `mem_req` 0, `mem_addr` 0.
  - `hit` 0 and `ir_code` NOP, because no line is valid.
  - Perf counters 0.
- **Hit latency:** 0 cycles; `ir_code` and `hit` follow `pc` combinationally.
- **Miss timing.**
  - Miss detected in cycle 0.
  - `mem_req` first high in cycle 1.
  - With memory acking in the same cycle as the request, acks occur in cycles 1..`LINE_WORDS`.
  - IDLE with a hit in cycle `LINE_WORDS+1`, i.e. cycle 5 at defaults.
  - Each memory wait cycle adds one cycle.
- **Reset mid-refill:** returns immediately to reset values; the partial line stays invalid; `mem_req` drops asynchronously.
- **Wrap-around:**
  - `cnt` wraps to 0 after the last word.
  - Perf counters wrap modulo 2^32.

## Configuration

- `ICACHE_PERF_EN` defined:
  - Adds the `perf_hits` and `perf_misses` ports and their registers.
  - `perf_hits` increments on each IDLE cycle with `req && hit`.
  - `perf_misses` increments on each transition IDLE→REFILL.
- `ICACHE_PERF_EN` undefined:
  - Ports and registers are absent.
  - Behaviour is otherwise identical.

## Test plan

Bench memory model: the word at address A is `A ^ 32'hA5A50000`, acked in the same cycle as the request unless stated otherwise.

- **Reset then cold fetch.**
  - Stimulus: `rst`=1 for 10 cycles, then `pc`=0, `req`=1.
  - Required: `hit`=0 and `ir_code`=`32'h00000013`; `mem_addr` sequence 0,4,8,C in cycles 1-4.
  - Required: `hit`=1 with `ir_code`=`32'hA5A50000` in cycle 5.
- **Same-line hits.**
  - Stimulus: after the refill, `pc` = 4, 8, C on successive cycles.
  - Required: `hit`=1 each cycle, `ir_code` = `A5A50004`, `A5A50008`, `A5A5000C`, and `mem_req` stays 0.
- **Conflict eviction.**
  - Stimulus: `pc`=`32'h100` (same index as 0 at defaults), then `pc`=0.
  - Required: a refill of `100..10C`, then a second refill of `0..C`; 2 misses total.
- **Wait-state memory.**
  - Stimulus: ack delayed 3 cycles per word.
  - Required: `mem_addr` held for 4 cycles per word; `hit` returns in cycle 17.
- **Flush during refill.**
  - Stimulus: assert `flush` in cycle 2 of the miss on `pc`=`32'h40`.
  - Required: all 4 words are still requested, then `hit`=0 and a new refill starts for `40`.
- **Perf counters (`ICACHE_PERF_EN`).**
  - Stimulus: 1 miss followed by 3 hits.
  - Required: `perf_misses`=1 and `perf_hits`=3; reset mid-refill returns both to 0 and `mem_req` to 0.
